sprite_datapath: RTL and testbench

- Per-object datapath answering the draw/erase/move sequencer; one instance each for car and pedestrian.
- Holds the object's top-left position and, while enabled, scans every pixel of a WIDTH x HEIGHT rectangle.
- Presents x_final/y_final/colour each cycle and pulses done on the last pixel.
- On a move strobe, steps the position horizontally with screen wrap-around.

---
 rtl/sprite_datapath_pkg.sv | 48 ++++
 rtl/sprite_datapath_pixel_scan_counter.sv | 60 ++++++
 rtl/sprite_datapath.sv | 89 ++++++++
 tb/tb_sprite_datapath.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sprite_datapath_pkg.sv
// ---------------------------------------------------------------------------
// sprite_datapath_pkg
//   Screen geometry, bus widths and named colours shared by the sprite
//   datapaths. Also holds the horizontal step function with wrap-around.
//   No ports (package).
// ---------------------------------------------------------------------------
package sprite_datapath_pkg;

   localparam int SCREEN_W    = 320;
   localparam int SCREEN_H    = 240;
   localparam int X_BITS      = 9;
   localparam int Y_BITS      = 8;
   localparam int COLOUR_BITS = 3;

   typedef logic [X_BITS-1:0]      x_t;
   typedef logic [Y_BITS-1:0]      y_t;
   typedef logic [COLOUR_BITS-1:0] colour_t;

   localparam colour_t BLACK   = 3'b000;
   localparam colour_t BLUE    = 3'b001;
   localparam colour_t GREEN   = 3'b010;
   localparam colour_t CYAN    = 3'b011;
   localparam colour_t RED     = 3'b100;
   localparam colour_t MAGENTA = 3'b101;
   localparam colour_t YELLOW  = 3'b110;
   localparam colour_t WHITE   = 3'b111;

   // The sequencer paints this over an object when erasing it.
   localparam colour_t BG_COLOUR = BLACK;

   // Step pos one move in direction dir (0 = right, 1 = left).
   // Right: the sum is formed in one extra bit so it cannot wrap silently;
   // anything beyond limit jumps back to column 0.
   // Left: a step that would go below 0 lands on limit.
   function automatic x_t step_x(input x_t pos, input logic dir,
                                 input int step, input int limit);
      logic [X_BITS:0] n;
      x_t              r;
      n = {1'b0, pos} + (X_BITS+1)'(step);
      if (!dir) begin
         r = (n > (X_BITS+1)'(limit)) ? '0 : n[X_BITS-1:0];
      end else begin
         r = (pos < x_t'(step)) ? x_t'(limit) : pos - x_t'(step);
      end
      return r;
   endfunction

endpackage

// File: rtl/sprite_datapath_pixel_scan_counter.sv
// ---------------------------------------------------------------------------
// pixel_scan_counter
//   Raster scan of a WIDTH x HEIGHT rectangle, column fastest.
//   Ports:
//     clock  in   rising-edge clock
//     resetn in   asynchronous active-low reset
//     en     in   advance the scan; low clears it back to (0,0)
//     col    out  current column (registered, 6 bits)
//     row    out  current row    (registered, 6 bits)
//     last   out  (col,row) is the final pixel; not qualified by en
// ---------------------------------------------------------------------------
module pixel_scan_counter #(
   parameter int WIDTH  = 8,
   parameter int HEIGHT = 8
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       en,
   output logic [5:0] col,
   output logic [5:0] row,
   output logic       last
);

   logic [5:0] col_q, col_d;
   logic [5:0] row_q, row_d;
   logic       col_end, row_end;

   assign col_end = (col_q == 6'(WIDTH - 1));
   assign row_end = (row_q == 6'(HEIGHT - 1));

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (!en) begin
         // Dropping en mid-pass restarts the next pass at (0,0).
         col_d = '0;
         row_d = '0;
      end else if (col_end) begin
         col_d = '0;
         row_d = row_end ? '0 : row_q + 6'd1;
      end else begin
         col_d = col_q + 6'd1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign col  = col_q;
   assign row  = row_q;
   assign last = col_end & row_end;

endmodule

// File: rtl/sprite_datapath.sv
// ---------------------------------------------------------------------------
// sprite_datapath
//   Per-object datapath (car or pedestrian). Holds the top-left position,
//   scans the sprite rectangle while en is high and steps the position
//   horizontally with screen wrap on a move strobe.
//   Ports:
//     clock    in   rising-edge clock
//     resetn   in   asynchronous active-low reset
//     en       in   scan enable, high for a whole draw/erase pass
//     can_move in   one-cycle move strobe, ignored while en is high
//     dir      in   0 = right (+x), 1 = left (-x)
//     x_final  out  pos_x + col
//     y_final  out  pos_y + row
//     colour   out  constant COLOUR
//     done     out  high while the final pixel is presented
//     pos_x    out  registered top-left x
//     pos_y    out  registered top-left y (fixed after reset)
//
//   Handshake: there is no backpressure. Every cycle with en high presents
//   exactly one pixel; the sequencer consumes it in that cycle and uses
//   done to know the pass is complete.
// ---------------------------------------------------------------------------
module sprite_datapath
   import sprite_datapath_pkg::*;
#(
   parameter int          WIDTH  = 8,
   parameter int          HEIGHT = 8,
   parameter int          X_INIT = 0,
   parameter int          Y_INIT = 100,
   parameter int          X_STEP = 4,
   parameter logic [2:0]  COLOUR = 3'b100
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       en,
   input  logic       can_move,
   input  logic       dir,
   output logic [8:0] x_final,
   output logic [7:0] y_final,
   output logic [2:0] colour,
   output logic       done,
   output logic [8:0] pos_x,
   output logic [7:0] pos_y
);

   localparam int X_LIMIT = SCREEN_W - WIDTH;

   logic [5:0] col, row;
   logic       last;
   x_t         pos_x_q, pos_x_d;
   y_t         pos_y_q;

   pixel_scan_counter #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT)
   ) u_scan (
      .clock  (clock),
      .resetn (resetn),
      .en     (en),
      .col    (col),
      .row    (row),
      .last   (last)
   );

   // Position is frozen during a pass so every pixel of it uses one origin.
   always_comb begin
      pos_x_d = pos_x_q;
      if (can_move && !en) begin
         pos_x_d = step_x(pos_x_q, dir, X_STEP, X_LIMIT);
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pos_x_q <= x_t'(X_INIT);
         pos_y_q <= y_t'(Y_INIT);
      end else begin
         pos_x_q <= pos_x_d;
      end
   end

   assign x_final = pos_x_q + {3'b000, col};
   assign y_final = pos_y_q + {2'b00, row};
   assign colour  = COLOUR;
   assign done    = en & last;
   assign pos_x   = pos_x_q;
   assign pos_y   = pos_y_q;

endmodule

// File: tb/tb_sprite_datapath.sv
module tb_sprite_datapath;

  localparam int W      = 4;
  localparam int H      = 2;
  localparam int XI     = 10;
  localparam int YI     = 20;
  localparam int XS     = 4;
  localparam int XL     = 320 - W;
  localparam logic [2:0] COL = 3'b100;

  // clock/reset
  logic clock = 1'b0;
  logic resetn = 1'b1;
  always #5 clock = ~clock;

  logic       en = 1'b0, can_move = 1'b0, dir = 1'b0;
  logic [8:0] x_final, pos_x, x_final1, pos_x1;
  logic [7:0] y_final, pos_y, y_final1, pos_y1;
  logic [2:0] colour, colour1;
  logic       done, done1;

  sprite_datapath #(.WIDTH(W), .HEIGHT(H), .X_INIT(XI), .Y_INIT(YI),
                    .X_STEP(XS), .COLOUR(COL)) dut (
    .clock(clock), .resetn(resetn), .en(en), .can_move(can_move), .dir(dir),
    .x_final(x_final), .y_final(y_final), .colour(colour), .done(done),
    .pos_x(pos_x), .pos_y(pos_y));

  // 1x1 sprite: done must follow en every cycle
  sprite_datapath #(.WIDTH(1), .HEIGHT(1)) dut1 (
    .clock(clock), .resetn(resetn), .en(en), .can_move(1'b0), .dir(1'b0),
    .x_final(x_final1), .y_final(y_final1), .colour(colour1), .done(done1),
    .pos_x(pos_x1), .pos_y(pos_y1));

  // scoreboard: {x_final, y_final, done, pos_x, pos_y}
  localparam int SBW = 9 + 8 + 1 + 9 + 8;
  logic [SBW-1:0] exp_q[$];
  int chk_cnt = 0;
  int pass_cnt = 0;

  // bench model
  int col_m = 0, row_m = 0, pos_m = XI;

  task automatic check(input string tag, input logic [SBW-1:0] obs,
                       input logic [SBW-1:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s got=%h exp=%h @%0t", tag, obs, exp, $time);
  endtask

  function automatic logic [SBW-1:0] model_out(input logic e);
    logic d;
    d = e && (col_m == W-1) && (row_m == H-1);
    return {9'(pos_m + col_m), 8'(YI + row_m), d, 9'(pos_m), 8'(YI)};
  endfunction

  task automatic model_reset();
    col_m = 0; row_m = 0; pos_m = XI;
  endtask

  task automatic model_edge(input logic e, input logic mv, input logic d);
    if (e) begin
      if (col_m == W-1) begin
        col_m = 0;
        row_m = (row_m == H-1) ? 0 : row_m + 1;
      end else col_m++;
    end else begin
      col_m = 0; row_m = 0;
      if (mv) begin
        if (!d) pos_m = (pos_m + XS > XL) ? 0 : pos_m + XS;
        else    pos_m = (pos_m < XS) ? XL : pos_m - XS;
      end
    end
  endtask

  task automatic pop_and_check(input string tag);
    logic [SBW-1:0] e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {x_final, y_final, done, pos_x, pos_y}, e);
    end
  endtask

  // driver: called just after a rising edge; drives one cycle
  task automatic cycle(input logic e, input logic mv, input logic d);
    en = e; can_move = mv; dir = d;
    exp_q.push_back(model_out(e));
    @(negedge clock);
    pop_and_check("cyc");
    check("done_1x1", SBW'(done1), SBW'(e));
    @(posedge clock);
    model_edge(e, mv, d);
    #1;
  endtask

  task automatic move(input logic d, input int expect_pos);
    cycle(1'b0, 1'b1, d);
    check("move_pos", SBW'(pos_x), SBW'(expect_pos));
  endtask

  initial begin
    // reset asserted mid-cycle: outputs must change without a clock edge
    #2 resetn = 1'b0;
    #1;
    model_reset();
    exp_q.push_back(model_out(1'b0));
    pop_and_check("reset");
    check("reset_colour", SBW'(colour), SBW'(COL));
    check("reset_x", SBW'(x_final), SBW'(XI));
    @(negedge clock) resetn = 1'b1;
    @(posedge clock); #1;

    // full scan, then idle, then a second full pass from (0,0)
    for (int i = 0; i < W*H; i++) cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)   cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < W*H; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    // abort after 3 pixels, restart, run past done
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2*W*H + 1; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    // move strobe during a pass is ignored
    for (int i = 0; i < W*H; i++) cycle(1'b1, 1'b1, i[0]);
    check("mid_pass_pos", SBW'(pos_x), SBW'(XI));

    // explicit wrap cases
    move(1'b1, 6);
    move(1'b1, 2);
    move(1'b1, XL);     // 2 - 4 wraps to 316
    move(1'b0, 0);      // 316 + 4 = 320 > 316
    move(1'b1, XL);
    move(1'b1, XL - 4); // 312
    move(1'b0, XL);     // 312 -> 316
    move(1'b0, 0);      // 316 -> 0
    move(1'b0, 4);
    move(1'b0, 8);
    move(1'b1, 4);      // 8 -> 4
    // scan at the new origin
    for (int i = 0; i < W*H; i++) cycle(1'b1, 1'b0, 1'b0);

    // random mix of scans and moves
    for (int i = 0; i < 120; i++)
      cycle(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));

    // reset mid-scan
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
    en = 1'b1;
    #2 resetn = 1'b0;
    #1;
    model_reset();
    exp_q.push_back(model_out(1'b1));
    pop_and_check("reset_mid_scan");
    check("reset_mid_done", SBW'(done), SBW'(0));
    en = 1'b0;
    @(negedge clock) resetn = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < W*H; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // hard time limit
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
